// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants for the hazard scoreboard and its operand matchers
package pipe_pkg;
   localparam int STG_EX = 0;
   localparam int STG_MEM = 1;
   localparam int STG_WB = 2;
   localparam int STAGES_DEF = STG_WB + 1;
   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 5;
   localparam int LOAD_READY_DEF = STG_MEM;
   // width of an entry's ready_at field; covers pipelines up to 16 tracked stages
   localparam int READY_W = 4;
endpackage

// File: rtl/hazard_fwd_match.sv
// hazard_fwd_match: youngest-match forward mux for one ID operand, returning data, hit and blocked
module hazard_fwd_match
   import pipe_pkg::*;
#(
   parameter int STAGES = STAGES_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic                      used,
   input  logic [REG_AW-1:0]         src,
   input  logic [STAGES-1:0]         entValid,
   input  logic [STAGES*REG_AW-1:0]  entAddr,
   input  logic [STAGES*READY_W-1:0] entReady,
   input  logic [STAGES*DATA_W-1:0]  stgData,
   input  logic [DATA_W-1:0]         rfData,
   output logic [DATA_W-1:0]         data,
   output logic                      hit,
   output logic                      blocked
);
   // scan oldest to youngest so the youngest match is the one left standing
   always_comb begin
      data = rfData;
      hit = 1'b0;
      blocked = 1'b0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         if (used && entValid[i] && entAddr[i*REG_AW +: REG_AW] == src) begin
            hit = i >= int'(entReady[i*READY_W +: READY_W]);
            blocked = !hit;
            data = hit ? stgData[i*DATA_W +: DATA_W] : rfData;
         end
      end
   end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight write scoreboard with operand forwarding and not-ready stall.
// Define HAZARD_STATS_EN to add the stall_cnt/fwd_cnt event counters.
module hazard_scoreboard
   import pipe_pkg::*;
#(
   parameter int STAGES = STAGES_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int LOAD_READY = LOAD_READY_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_en,
   input  logic                     id_valid,
   input  logic [REG_AW-1:0]        id_rs_addr,
   input  logic [REG_AW-1:0]        id_rt_addr,
   input  logic                     id_rs_used,
   input  logic                     id_rt_used,
   input  logic                     id_wr_en,
   input  logic [REG_AW-1:0]        id_wr_addr,
   input  logic                     id_is_load,
   input  logic                     flush,
   input  logic [STAGES*DATA_W-1:0] stg_data,
   input  logic [DATA_W-1:0]        rf_rs_data,
   input  logic [DATA_W-1:0]        rf_rt_data,
   output logic [DATA_W-1:0]        rs_data,
   output logic [DATA_W-1:0]        rt_data,
   output logic                     rs_fwd_hit,
   output logic                     rt_fwd_hit,
   output logic                     stall
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]              stall_cnt,
   output logic [31:0]              fwd_cnt
`endif
);
   logic [STAGES-1:0] entValid;
   logic [STAGES*REG_AW-1:0] entAddr;
   logic [STAGES*READY_W-1:0] entReady;
   logic rsBlocked, rtBlocked, newValid;
   logic [READY_W-1:0] newReady;

   hazard_fwd_match #(.STAGES(STAGES), .DATA_W(DATA_W), .REG_AW(REG_AW)) rsMatch (
      .used(id_rs_used), .src(id_rs_addr), .entValid(entValid), .entAddr(entAddr),
      .entReady(entReady), .stgData(stg_data), .rfData(rf_rs_data),
      .data(rs_data), .hit(rs_fwd_hit), .blocked(rsBlocked)
   );

   hazard_fwd_match #(.STAGES(STAGES), .DATA_W(DATA_W), .REG_AW(REG_AW)) rtMatch (
      .used(id_rt_used), .src(id_rt_addr), .entValid(entValid), .entAddr(entAddr),
      .entReady(entReady), .stgData(stg_data), .rfData(rf_rt_data),
      .data(rt_data), .hit(rt_fwd_hit), .blocked(rtBlocked)
   );

   // flush outranks stall: a squashed instruction must not hold the front end
   assign stall = id_valid && !flush && (rsBlocked || rtBlocked);
   assign newValid = id_valid && !flush && !stall && id_wr_en && id_wr_addr != '0;
   assign newReady = id_is_load ? READY_W'(LOAD_READY) : READY_W'(STG_EX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entValid <= '0;
         entAddr <= '0;
         entReady <= '0;
      end else if (cpu_en) begin
         entValid <= {entValid[STAGES-2:STG_EX], newValid};
         entAddr <= {entAddr[(STAGES-1)*REG_AW-1:0], id_wr_addr};
         entReady <= {entReady[(STAGES-1)*READY_W-1:0], newReady};
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         fwd_cnt <= '0;
      end else if (cpu_en) begin
         stall_cnt <= stall_cnt + 32'(stall);
         fwd_cnt <= fwd_cnt + 32'(rs_fwd_hit || rt_fwd_hit);
      end
   end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed hazard scenarios checked against an age-list model of in-flight writes
module tb_hazard_scoreboard;
   localparam int ST = 3;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int LR = 1;

   logic clk = 1'b0, rst = 1'b1, cpu_en = 1'b1, id_valid = 1'b0;
   logic [AW-1:0] id_rs_addr = '0, id_rt_addr = '0, id_wr_addr = '0;
   logic id_rs_used = 1'b0, id_rt_used = 1'b0, id_wr_en = 1'b0, id_is_load = 1'b0, flush = 1'b0;
   logic [ST*DW-1:0] stg_data = '0;
   logic [DW-1:0] rf_rs_data = '0, rf_rt_data = '0;
   logic [DW-1:0] rs_data, rt_data;
   logic rs_fwd_hit, rt_fwd_hit, stall;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt, fwd_cnt;
   logic [31:0] expStallCnt = '0, expFwdCnt = '0;
`endif

   int checks = 0;
   int failures = 0;

   typedef struct {
      int addr;
      bit ld;
      int age;
   } rec_t;
   rec_t q[$];

   hazard_scoreboard #(.STAGES(ST), .DATA_W(DW), .REG_AW(AW), .LOAD_READY(LR)) dut (
      .clk(clk), .rst(rst), .cpu_en(cpu_en), .id_valid(id_valid),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .flush(flush),
      .stg_data(stg_data), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
      .rs_data(rs_data), .rt_data(rt_data), .rs_fwd_hit(rs_fwd_hit), .rt_fwd_hit(rt_fwd_hit), .stall(stall)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // youngest in-flight write (smallest age) to src decides; it forwards once its age reaches its ready stage
   function automatic void evalOp(input bit used, input logic [AW-1:0] src, input logic [DW-1:0] rf,
                                  output logic [DW-1:0] d, output bit hit, output bit blk);
      int best = -1;
      d = rf;
      hit = 0;
      blk = 0;
      if (used)
         foreach (q[k])
            if (q[k].addr == int'(src) && (best < 0 || q[k].age < q[best].age)) best = k;
      if (best >= 0) begin
         if (q[best].age >= (q[best].ld ? LR : 0)) begin
            hit = 1;
            d = stg_data[q[best].age*DW +: DW];
         end else blk = 1;
      end
   endfunction

   function automatic void evalAll(output logic [DW-1:0] rsD, output bit rsH, output bit rsB,
                                   output logic [DW-1:0] rtD, output bit rtH, output bit rtB, output bit st);
      evalOp(id_rs_used, id_rs_addr, rf_rs_data, rsD, rsH, rsB);
      evalOp(id_rt_used, id_rt_addr, rf_rt_data, rtD, rtH, rtB);
      st = id_valid && !flush && (rsB || rtB);
   endfunction

   initial forever begin : model
      logic [DW-1:0] rsD, rtD;
      bit rsH, rsB, rtH, rtB, st;
      rec_t r;
      @(posedge clk or posedge rst);
      if (rst) begin
         q.delete();
`ifdef HAZARD_STATS_EN
         expStallCnt = '0;
         expFwdCnt = '0;
`endif
      end else if (cpu_en) begin
         evalAll(rsD, rsH, rsB, rtD, rtH, rtB, st);
`ifdef HAZARD_STATS_EN
         expStallCnt += 32'(st);
         expFwdCnt += 32'(rsH || rtH);
`endif
         foreach (q[k]) q[k].age++;
         for (int k = q.size() - 1; k >= 0; k--)
            if (q[k].age >= ST) q.delete(k);
         if (id_valid && !flush && !st && id_wr_en && id_wr_addr != '0) begin
            r.addr = int'(id_wr_addr);
            r.ld = id_is_load;
            r.age = 0;
            q.push_back(r);
         end
      end
   end

   initial forever begin : compare
      logic [DW-1:0] rsD, rtD;
      bit rsH, rsB, rtH, rtB, st;
      @(negedge clk);
      if (!rst) begin
         evalAll(rsD, rsH, rsB, rtD, rtH, rtB, st);
         chk("cyc_rs_hit", 32'(rs_fwd_hit), 32'(rsH));
         chk("cyc_rt_hit", 32'(rt_fwd_hit), 32'(rtH));
         chk("cyc_stall", 32'(stall), 32'(st));
         if (!rsB) chk("cyc_rs_data", rs_data, rsD);
         if (!rtB) chk("cyc_rt_data", rt_data, rtD);
`ifdef HAZARD_STATS_EN
         chk("cyc_stall_cnt", stall_cnt, expStallCnt);
         chk("cyc_fwd_cnt", fwd_cnt, expFwdCnt);
`endif
      end
   end

   task automatic drive(input logic v, input logic [AW-1:0] rs, input logic ru, input logic [AW-1:0] rt,
                        input logic tu, input logic we, input logic [AW-1:0] wa, input logic ld);
      id_valid = v;
      id_rs_addr = rs;
      id_rs_used = ru;
      id_rt_addr = rt;
      id_rt_used = tu;
      id_wr_en = we;
      id_wr_addr = wa;
      id_is_load = ld;
      flush = 1'b0;
   endtask

   task automatic settle;
      @(negedge clk);
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic bubbles;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (ST) tick;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rf_rs_data = 32'hAAAA_0001;
      rf_rt_data = 32'hBBBB_0002;
      stg_data = {32'h0000_0222, 32'hDEAD_BEEF, 32'h0000_0010};
      drive(1, 3, 1, 3, 1, 1, 3, 0);
      settle;
      chk("reset_stall", 32'(stall), 0);
      chk("reset_rs_hit", 32'(rs_fwd_hit), 0);
      chk("reset_rs_data", rs_data, 32'hAAAA_0001);
      tick;
      rst = 1'b0;
      bubbles;
      // ALU back-to-back: add r3, then sub r4 reading r3
      drive(1, 1, 1, 2, 1, 1, 3, 0);
      settle;
      chk("alu_first_hit", 32'(rs_fwd_hit), 0);
      tick;
      drive(1, 3, 1, 2, 1, 1, 4, 0);
      settle;
      chk("alu_b2b_hit", 32'(rs_fwd_hit), 1);
      chk("alu_b2b_data", rs_data, 32'h0000_0010);
      chk("alu_b2b_stall", 32'(stall), 0);
      tick;
      bubbles;
      // load-use: one stall, then forwarded from stage 1
      drive(1, 1, 1, 2, 1, 1, 5, 1);
      settle;
      tick;
      drive(1, 5, 1, 2, 1, 1, 6, 0);
      settle;
      chk("lu_stall", 32'(stall), 1);
      chk("lu_stall_hit", 32'(rs_fwd_hit), 0);
      tick;
      settle;
      chk("lu_after_stall", 32'(stall), 0);
      chk("lu_after_hit", 32'(rs_fwd_hit), 1);
      chk("lu_after_data", rs_data, 32'hDEAD_BEEF);
      tick;
      bubbles;
      // r0 never recorded; unused rt never stalls
      rf_rs_data = '0;
      drive(1, 1, 1, 2, 1, 1, 0, 0);
      settle;
      tick;
      drive(1, 0, 1, 2, 1, 0, 0, 0);
      settle;
      chk("r0_hit", 32'(rs_fwd_hit), 0);
      chk("r0_data", rs_data, 32'h0);
      tick;
      rf_rs_data = 32'hAAAA_0001;
      drive(1, 1, 1, 2, 1, 1, 6, 1);
      settle;
      tick;
      drive(1, 1, 1, 6, 0, 0, 0, 0);
      settle;
      chk("unused_rt_stall", 32'(stall), 0);
      chk("unused_rt_hit", 32'(rt_fwd_hit), 0);
      chk("unused_rt_data", rt_data, 32'hBBBB_0002);
      tick;
      bubbles;
      // youngest wins among ALU writes
      stg_data = {32'h0000_0333, 32'h0000_0001, 32'h0000_0002};
      drive(1, 1, 0, 2, 0, 1, 7, 0);
      settle;
      tick;
      settle;
      tick;
      drive(1, 7, 1, 2, 0, 0, 0, 0);
      settle;
      chk("young_hit", 32'(rs_fwd_hit), 1);
      chk("young_data", rs_data, 32'h0000_0002);
      tick;
      bubbles;
      // younger not-ready load masks older ready ALU write
      stg_data = {32'h0000_0222, 32'hDEAD_BEEF, 32'h0000_0010};
      drive(1, 1, 0, 2, 0, 1, 8, 0);
      settle;
      tick;
      drive(1, 1, 0, 2, 0, 1, 8, 1);
      settle;
      tick;
      drive(1, 8, 1, 2, 0, 0, 0, 0);
      settle;
      chk("mask_stall", 32'(stall), 1);
      tick;
      settle;
      chk("mask_after_stall", 32'(stall), 0);
      chk("mask_after_data", rs_data, 32'hDEAD_BEEF);
      tick;
      bubbles;
      // flush during stall inserts a bubble and drops the squashed write
      drive(1, 1, 0, 2, 0, 1, 9, 1);
      settle;
      tick;
      drive(1, 9, 1, 2, 0, 1, 10, 0);
      flush = 1'b1;
      settle;
      chk("flush_stall", 32'(stall), 0);
      tick;
      drive(1, 10, 1, 2, 0, 0, 0, 0);
      settle;
      chk("flush_r10_hit", 32'(rs_fwd_hit), 0);
      chk("flush_r10_data", rs_data, 32'hAAAA_0001);
      tick;
      bubbles;
      // cpu_en low freezes the scoreboard
      drive(1, 1, 0, 2, 0, 1, 11, 1);
      settle;
      tick;
      drive(1, 11, 1, 2, 0, 0, 0, 0);
      settle;
      chk("freeze_stall_pre", 32'(stall), 1);
      cpu_en = 1'b0;
      tick;
      tick;
      settle;
      chk("freeze_stall_hold", 32'(stall), 1);
      cpu_en = 1'b1;
      tick;
      settle;
      chk("freeze_release_stall", 32'(stall), 0);
      chk("freeze_release_hit", 32'(rs_fwd_hit), 1);
      tick;
      bubbles;
      // async reset between edges during a load-use stall
      drive(1, 1, 0, 2, 0, 1, 12, 1);
      settle;
      tick;
      drive(1, 12, 1, 2, 0, 0, 0, 0);
      #1;
      chk("arst_stall_pre", 32'(stall), 1);
      rst = 1'b1;
      #1;
      chk("arst_stall", 32'(stall), 0);
      chk("arst_hit", 32'(rs_fwd_hit), 0);
      chk("arst_data", rs_data, 32'hAAAA_0001);
`ifdef HAZARD_STATS_EN
      chk("arst_stall_cnt", stall_cnt, 0);
      chk("arst_fwd_cnt", fwd_cnt, 0);
`endif
      rst = 1'b0;
      settle;
      chk("arst_after_stall", 32'(stall), 0);
      tick;
      bubbles;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
